phanxu8_rr: RTL

Eight-requester round-robin arbiter that shares one resource port among eight clients. The granted client is reported one-hot on `gnt` and as a binary index on `gnt_idx`, so the arbiter can drive the resource mux directly. Grants are registered and held until the owner releases. A programmable hold limit stops any one client from monopolising the resource.

---
 rtl/phanxu8_rr_pkg.sv | 17 +
 rtl/phanxu8_rr_uutien8_3.sv | 19 +
 rtl/phanxu8_rr.sv | 109 ++++++++++
 3 files changed

// File: rtl/phanxu8_rr_pkg.sv
// Shared constants, state encoding and rotate helper for the phanxu8 round-robin arbiter.
package phanxu8_rr_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Rotate right so that bit `s` of v lands at bit 0.
  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input logic [IDX_W-1:0] s);
    logic [2*N-1:0] d;
    d = {v, v} >> s;
    return d[N-1:0];
  endfunction
endpackage

// File: rtl/phanxu8_rr_uutien8_3.sv
// Combinational 8->3 priority encoder: lowest set bit index plus a found flag.
module uutien8_3
  import phanxu8_rr_pkg::*;
(
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/phanxu8_rr.sv
// Eight-way round-robin arbiter with registered one-hot/index grant and a hold limit.
module phanxu8_rr
  import phanxu8_rr_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             preempt_o
);
  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pre_q, pre_d;

  logic [IDX_W-1:0] base;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] enc_idx, sel_idx;
  logic             found;
  logic             owner_req, hold_hit;

  // One encoder serves both cases: from ptr when idle, from just past the
  // owner (owner masked out) when busy.
  always_comb begin
    base = (state_q == ST_BUSY) ? idx_q + 1'b1 : ptr_q;
    cand = (state_q == ST_BUSY) ? (req_i & ~gnt_q) : req_i;
  end

  uutien8_3 u_enc (
    .vec_i   (rotr(cand, base)),
    .idx_o   (enc_idx),
    .found_o (found)
  );

  assign sel_idx   = enc_idx + base;
  assign owner_req = req_i[idx_q];
  assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    pre_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          gnt_d   = N'(1) << sel_idx;
          idx_d   = sel_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (!owner_req || hold_hit) begin
          // Release wins over a simultaneous hold-limit expiry.
          ptr_d = idx_q + 1'b1;
          pre_d = owner_req;
          cnt_d = '0;
          if (found) begin
            gnt_d = N'(1) << sel_idx;
            idx_d = sel_idx;
          end else if (!owner_req) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = (state_q == ST_BUSY);
  assign preempt_o   = pre_q;
endmodule
